// File: rtl/mio_bus.sv
// Memory/IO bus responder: decodes CPU MemRead/MemWrite requests onto block RAM,
// display/LED/switch registers and a free-running counter, returning a one-cycle ready.
module mio_bus #(
  parameter int RAM_AW      = 10,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Data4CPU,
  output logic [31:0]       Data2CPU,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       SW,
  output logic [15:0]       LED,
  output logic [31:0]       disp_data,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, RAM_RD, RAM_CAP, RESP} state_t;

  localparam logic [1:0]  LAT_LAST  = 2'(RAM_LATENCY - 1);
  localparam logic [31:0] ADDR_DISP = 32'hE000_0000;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0000;
  localparam logic [31:0] ADDR_CNT  = 32'hF000_0004;

  state_t      state, next_state;
  logic [1:0]  lat_cnt;
  logic [31:0] counter;

  logic is_ram, is_disp, is_sw, is_cnt, unmapped;
  logic accept, wr, rd;

  assign is_ram   = (addr_bus[31:RAM_AW+2] == '0);
  assign is_disp  = (addr_bus == ADDR_DISP);
  assign is_sw    = (addr_bus == ADDR_SW);
  assign is_cnt   = (addr_bus == ADDR_CNT);
  assign unmapped = ~(is_ram | is_disp | is_sw | is_cnt);

  // Write wins when both strobes are high; the conflict itself is flagged in bus_err.
  assign accept = (state == IDLE) && (mem_r || mem_w);
  assign wr     = mem_w;
  assign rd     = mem_r && !mem_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: next_state gets a default before the case so no path can infer a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (mem_r || mem_w) next_state = (rd && is_ram) ? RAM_RD : RESP;
      RAM_RD:  if (lat_cnt == LAT_LAST) next_state = RAM_CAP;
      RAM_CAP: next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every register here updates with <= so all of them see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Data2CPU  <= '0;
      MIO_ready <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      LED       <= '0;
      disp_data <= '0;
      bus_err   <= 1'b0;
      counter   <= '0;
      lat_cnt   <= '0;
    end else begin
      MIO_ready <= (next_state == RESP);
      ram_we    <= accept && wr && is_ram;
      counter   <= counter + 32'd1;
      lat_cnt   <= (state == RAM_RD) ? lat_cnt + 2'd1 : 2'd0;

      if (accept) begin
        if (is_ram) ram_addr <= addr_bus[RAM_AW+1:2];
        if (wr && is_ram) ram_din <= Data4CPU;
        if (wr && is_disp) disp_data <= Data4CPU;
        if (wr && is_sw) LED <= Data4CPU[15:0];
        if (wr && is_cnt) counter <= Data4CPU;
        if (rd && is_disp) Data2CPU <= disp_data;
        if (rd && is_sw) Data2CPU <= {16'h0, SW};
        if (rd && is_cnt) Data2CPU <= counter;
        if (unmapped) Data2CPU <= '0;
        if (unmapped || (mem_r && mem_w)) bus_err <= 1'b1;
      end

      if (state == RAM_CAP) Data2CPU <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mio_bus.sv
// Directed bench for mio_bus: a latency-1 RAM model, a scoreboard queue of expected
// completions, and immediate assertions at every comparison point.
module tb_mio_bus;

  localparam int RAM_AW = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_r, mem_w;
  logic [31:0]       addr_bus, Data4CPU, Data2CPU;
  logic              MIO_ready;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_din, ram_dout;
  logic              ram_we;
  logic [15:0]       SW, LED;
  logic [31:0]       disp_data;
  logic              bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          lat;
    logic [31:0] data;
    bit          chk;
  } exp_t;
  exp_t sb[$];

  int          we_cnt;
  logic [31:0] we_addr, we_din;

  logic [31:0] ram_mem [2**RAM_AW];

  mio_bus #(.RAM_AW(RAM_AW), .RAM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .mem_r(mem_r), .mem_w(mem_w),
    .addr_bus(addr_bus), .Data4CPU(Data4CPU), .Data2CPU(Data2CPU),
    .MIO_ready(MIO_ready), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout), .SW(SW), .LED(LED),
    .disp_data(disp_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Starts a request in the current (IDLE) cycle, waits for ready, checks the
  // completion against the scoreboard and returns in the following IDLE cycle.
  task automatic do_txn(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int lat,
                        input logic [31:0] exp_d, input bit chk_d, input string tag);
    exp_t e;
    int   n    = 0;
    bit   seen = 0;
    e.lat = lat; e.data = exp_d; e.chk = chk_d;
    sb.push_back(e);
    mem_r = r; mem_w = w; addr_bus = a; Data4CPU = d;
    we_cnt = 0; we_addr = 'x; we_din = 'x;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (ram_we) begin
        we_cnt++;
        we_addr = 32'(ram_addr);
        we_din  = ram_din;
      end
      if (MIO_ready) seen = 1;
    end
    mem_r = 1'b0; mem_w = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      check({tag, "_timeout"}, 32'(MIO_ready), 32'd1);
    end else begin
      check({tag, "_lat"}, 32'(n), 32'(e.lat));
      if (e.chk) check({tag, "_data"}, Data2CPU, e.data);
    end
    @(negedge clk);
    check({tag, "_single_ready"}, 32'(MIO_ready), 32'd0);
  endtask

  initial begin
    int rdy_cnt;
    reset = 1'b1; mem_r = 1'b0; mem_w = 1'b0;
    addr_bus = '0; Data4CPU = '0; SW = 16'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", 32'(MIO_ready), 32'd0);
    check("rst_data", Data2CPU, 32'd0);
    check("rst_led", 32'(LED), 32'd0);
    check("rst_disp", disp_data, 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_we", 32'(ram_we), 32'd0);
    @(negedge clk);

    // RAM write then read of the same word.
    do_txn(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1, '0, 1'b0, "ram_wr");
    check("ram_wr_we_cnt", 32'(we_cnt), 32'd1);
    check("ram_wr_addr", we_addr, 32'd4);
    check("ram_wr_din", we_din, 32'h1234_5678);
    do_txn(1'b1, 1'b0, 32'h0000_0010, '0, 3, 32'h1234_5678, 1'b1, "ram_rd");

    // Top word of RAM, low address bits ignored.
    do_txn(1'b0, 1'b1, 32'h0000_0FFF, 32'hDEAD_BEEF, 1, '0, 1'b0, "ram_top_wr");
    check("ram_top_addr", we_addr, 32'h3FF);
    do_txn(1'b1, 1'b0, 32'h0000_0FFC, '0, 3, 32'hDEAD_BEEF, 1'b1, "ram_top_rd");

    // Peripherals.
    SW = 16'hA5A5;
    do_txn(1'b1, 1'b0, 32'hF000_0000, '0, 1, 32'h0000_A5A5, 1'b1, "sw_rd");
    do_txn(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_00FF, 1, '0, 1'b0, "led_wr");
    check("led_val", 32'(LED), 32'h0000_00FF);
    do_txn(1'b0, 1'b1, 32'hE000_0000, 32'hCAFE_F00D, 1, '0, 1'b0, "disp_wr");
    check("disp_val", disp_data, 32'hCAFE_F00D);
    do_txn(1'b1, 1'b0, 32'hE000_0000, '0, 1, 32'hCAFE_F00D, 1'b1, "disp_rd");
    check("err_clean", 32'(bus_err), 32'd0);

    // Counter: written at the accepting edge, then read when it has advanced to 1.
    do_txn(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 1, '0, 1'b0, "cnt_wr");
    repeat (2) @(negedge clk);
    do_txn(1'b1, 1'b0, 32'hF000_0004, '0, 1, 32'h0000_0001, 1'b1, "cnt_rd");

    // Read and write together: handled as a write, flagged as an error.
    do_txn(1'b1, 1'b1, 32'hE000_0000, 32'h1111_2222, 1, 32'h0000_0001, 1'b1, "conflict");
    check("conflict_disp", disp_data, 32'h1111_2222);
    check("conflict_err", 32'(bus_err), 32'd1);

    // Reset while the FSM is in RAM_RD.
    mem_r = 1'b1; addr_bus = 32'h0000_0010;
    @(negedge clk);
    mem_r = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(MIO_ready), 32'd0);
    check("mid_rst_data", Data2CPU, 32'd0);
    check("mid_rst_addr", 32'(ram_addr), 32'd0);
    check("mid_rst_disp", disp_data, 32'd0);
    check("mid_rst_led", 32'(LED), 32'd0);
    check("mid_rst_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rdy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (MIO_ready) rdy_cnt++;
    end
    check("mid_rst_no_ready", 32'(rdy_cnt), 32'd0);
    do_txn(1'b1, 1'b0, 32'h0000_0010, '0, 3, 32'h1234_5678, 1'b1, "post_rst_rd");
    check("post_rst_err", 32'(bus_err), 32'd0);

    // Unmapped accesses: no side effects, zero data, sticky error.
    do_txn(1'b1, 1'b0, 32'h8000_0000, '0, 1, 32'h0, 1'b1, "unmapped_rd");
    check("unmapped_err", 32'(bus_err), 32'd1);
    do_txn(1'b0, 1'b1, 32'h0000_1000, 32'h5555_AAAA, 1, '0, 1'b0, "unmapped_wr");
    check("unmapped_wr_we", 32'(we_cnt), 32'd0);
    check("unmapped_wr_led", 32'(LED), 32'd0);
    do_txn(1'b0, 1'b1, 32'hF000_0008, 32'h0000_FFFF, 1, '0, 1'b0, "near_miss_wr");
    check("near_miss_led", 32'(LED), 32'd0);
    do_txn(1'b1, 1'b0, 32'h0000_0FFC, '0, 3, 32'hDEAD_BEEF, 1'b1, "err_hold_rd");
    check("err_held", 32'(bus_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
